instr_fetch_unit: RTL

IF-stage fetch engine feeding the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to a variable-latency instruction memory over a req/gnt + rvalid handshake.
- Buffers returned words with their PCs in a small FIFO.
- Presents one instruction per cycle downstream and honours the pipeline's stall and branch-flush signals, discarding stale in-flight responses after a redirect.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch engine.
package fetch_pkg;

  localparam int              XLEN        = 32;
  localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0;
  localparam int              INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory handshake plus the IF/ID-facing pipeline signals.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            stall_i;
  logic            flush_i;
  logic [XLEN-1:0] branch_target_i;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] pc_o;
  logic            valid_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_o, pc_o, valid_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, stall_i, flush_i, branch_target_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_o, pc_o, valid_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, stall_i, flush_i, branch_target_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with power-of-two depth, synchronous clear and
// pop-while-full support.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: reads are only meaningful while count > 0.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF-stage fetch engine: credit-limited in-order requests to instruction
// memory, response buffering with PCs, and flush-time discard of stale data.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input logic                clk_i,
  input logic                start_i,
  instr_fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic            armed;

  logic [CW-1:0]   ibuf_count;
  logic            ibuf_full;
  logic            ibuf_empty;
  fetch_entry_t    ibuf_head;
  fetch_entry_t    ibuf_entry;

  logic [CW-1:0]   pcq_count;
  logic            pcq_full;
  logic            pcq_empty;
  logic [XLEN-1:0] pcq_head;

  logic [CW:0]     credit_used;
  logic            req;
  logic            accept;
  logic            resp;
  logic            drop;
  logic            keep;
  logic            ibuf_pop;
  logic            pcq_pop;
  logic [CW-1:0]   outstanding_next;

  // Buffered words plus in-flight requests never exceed the buffer depth,
  // so every granted request is guaranteed a slot on return.
  assign credit_used = {1'b0, outstanding} + {1'b0, ibuf_count};
  assign req         = start_i & (credit_used < (CW+1)'(FIFO_DEPTH)) & ~bus.flush_i;
  assign accept      = req & bus.imem_gnt_i;

  // A response with nothing outstanding (e.g. leftover from before reset) is ignored.
  assign resp     = bus.imem_rvalid_i & (outstanding != '0);
  assign drop     = resp & (discard != '0);
  assign keep     = resp & ~drop & ~bus.flush_i;
  assign pcq_pop  = resp & ~drop;
  assign ibuf_pop = ~ibuf_empty & ~bus.stall_i & ~bus.flush_i;

  assign outstanding_next = outstanding + CW'(accept) - CW'(resp);

  assign ibuf_entry.instr = bus.imem_rdata_i;
  assign ibuf_entry.pc    = pcq_head;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_ibuf (
    .clk_i   (clk_i),
    .start_i (start_i),
    .push    (keep),
    .pop     (ibuf_pop),
    .clear   (bus.flush_i),
    .wdata   (ibuf_entry),
    .rdata   (ibuf_head),
    .full    (ibuf_full),
    .empty   (ibuf_empty),
    .count   (ibuf_count)
  );

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_pcq (
    .clk_i   (clk_i),
    .start_i (start_i),
    .push    (accept),
    .pop     (pcq_pop),
    .clear   (bus.flush_i),
    .wdata   (fetch_pc),
    .rdata   (pcq_head),
    .full    (pcq_full),
    .empty   (pcq_empty),
    .count   (pcq_count)
  );

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      armed       <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      if (bus.flush_i) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= bus.branch_target_i;
        discard  <= outstanding_next;
      end else begin
        if (accept) fetch_pc <= next_pc(fetch_pc);
        if (drop)   discard  <= discard - CW'(1);
      end
      if (accept) armed <= 1'b1;
    end
  end

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = fetch_pc;
  assign bus.valid_o     = ~ibuf_empty;
  assign bus.instr_o     = ibuf_empty ? NOP_INSTR : ibuf_head.instr;
  assign bus.pc_o        = ibuf_empty ? '0 : ibuf_head.pc;

  a_rvalid_needs_outstanding : assert property (@(posedge clk_i) disable iff (!start_i)
    (bus.imem_rvalid_i && armed) |-> (outstanding != '0));

  a_ibuf_no_overflow : assert property (@(posedge clk_i) disable iff (!start_i)
    !(keep && ibuf_full && !ibuf_pop));

  a_pcq_no_overflow : assert property (@(posedge clk_i) disable iff (!start_i)
    !(accept && pcq_full && !pcq_pop));

  a_kept_word_has_pc : assert property (@(posedge clk_i) disable iff (!start_i)
    keep |-> !pcq_empty);

  a_inflight_accounting : assert property (@(posedge clk_i) disable iff (!start_i)
    ({1'b0, pcq_count} + {1'b0, discard}) == {1'b0, outstanding});

endmodule
